tdc_capture_ctrl: RTL
=====================

# tdc_capture_ctrl

Capture controller and initiator for the TDC fine-time decoder. It watches the registered tapped-delay-line sample and detects a hit edge. It freezes the tap vector for the decoder, runs the go/finished handshake, and tags the decoded fine code with a free-running coarse counter. The result is a timestamp word behind a valid/ready output toward the readout path.

## Interface
Parameters:
- NUM_TAPS, 36: width of the delay-line sample and of the frozen tap vector.
- NUM_DECODE, 8: width of the decoder result.
- COARSE_W, 24: width of the coarse counter.
- FALLING, 1'b0: must match the decoder's falling setting. Idle pattern is all-zeros when 0 and all-ones when 1.
- TIMEOUT, 16: maximum number of WAIT cycles allowed for finished.

Ports (name, direction, width, meaning):
- clk, input, 1: single clock.
- rst, input, 1: reset, synchronous and active-high.
- iEnable, input, 1: level; when 0, new hits are ignored.
- iTaps, input, NUM_TAPS: delay-line sample, already registered in clk.
- oGo, output, 1: one-cycle start pulse to the decoder.
- oDecodeIn, output, NUM_TAPS: frozen tap vector to the decoder.
- iFinished, input, 1: decoder done pulse.
- iDecodeOut, input, NUM_DECODE: decoder result, valid while iFinished=1.
- oTsValid, output, 1: timestamp valid.
- oTsData, output, 1+COARSE_W+NUM_DECODE: timestamp word {err, coarse, fine}.
- iTsReady, input, 1: downstream accept.
- oBusy, output, 1: state is not IDLE.
- oDropCnt, output, 8: count of lost hits, saturating.

## Operation
- **Idle pattern:** IDLE_PAT = {NUM_TAPS{FALLING}}.
- **Hit detection:** hit = (iTaps != IDLE_PAT) && (prev == IDLE_PAT). prev is iTaps registered every cycle regardless of state.
- **Coarse counter:** free-running, +1 every cycle, wraps from 2^COARSE_W-1 to 0.
- **IDLE:** on hit && iEnable, latch oDecodeIn<=iTaps and coarse_lat<=coarse, then go to LAUNCH.
- **LAUNCH:** oGo=1 for this cycle only. Clear the timeout counter. Go to WAIT. iFinished is ignored in this state.
- **WAIT:**
  - If iFinished=1: fine_lat<=iDecodeOut, err<=0, go to OUTPUT.
  - Else, when the timeout counter reaches TIMEOUT-1: fine_lat<=0, err<=1, go to OUTPUT.
  - iFinished and expiry in the same cycle: finished wins.
- **OUTPUT:** oTsValid=1 and oTsData={err, coarse_lat, fine_lat}, both held stable until iTsReady=1. On the accept cycle, go to IDLE.
- **oDecodeIn stability:** constant from latch until the cycle after accept.
- **Drops:** a hit with iEnable=1 while the state is not IDLE increments oDropCnt, saturating at 255. This includes the OUTPUT accept cycle. A hit while iEnable=0 is not counted.
- **Enable deassertion:** deasserting iEnable mid-transaction does not abort; the transaction completes normally.
- **Reset:** applies in any state, including mid-WAIT or mid-OUTPUT; the pending timestamp is discarded.

## Timing
- **Reset values:** oGo=0, oDecodeIn=0, oTsValid=0, oTsData=0, oBusy=0, oDropCnt=0, coarse=0, prev=IDLE_PAT, state=IDLE.
- **Hit to oGo:** hit seen at cycle N (IDLE); oGo=1 at N+1.
- **finished to valid:** iFinished at cycle M (WAIT); oTsValid=1 at M+1.
- **Timeout:** with no finished, oTsValid=1 at N+2+TIMEOUT.
- **Coarse latch:** coarse_lat equals the counter value at cycle N.
- **Back-to-back:** accept at cycle K; IDLE at K+1; the earliest new hit is taken at K+1.
- **Glitch free:** all outputs are registered.

## Structure
- Package tdc_pkg holds:
  - NUM_TAPS, NUM_DECODE, COARSE_W.
  - State enum: IDLE, LAUNCH, WAIT, OUTPUT.
  - Timestamp field offsets.
- Sub-module tdc_hit_detect holds the prev register, the IDLE_PAT compare and the hit output; it is reusable per channel.
- The FSM, counters and output register live in the top module.

## Test plan
All scenarios use FALLING=0 and a decoder stub that pulses finished 3 cycles after go.
- **Basic capture:** iTaps goes from 0 to 36'h00000000F with coarse=100 at the hit cycle; stub returns 8'd4. Expect oGo one cycle later, then oTsData={0, 24'd100, 8'd4} with iTsReady=1.
- **Backpressure:** hold iTsReady=0 for 10 cycles. Expect oTsValid and oTsData stable, and oDecodeIn stable. After accept, oBusy=0.
- **Timeout:** stub never finishes, TIMEOUT=16. Expect oTsValid exactly 18 cycles after the hit, with oTsData={1, coarse_lat, 8'd0}.
- **Drop and saturation:**
  - Three hits during WAIT: oDropCnt=3.
  - A hit on the accept cycle is also counted.
  - 300 forced drops: oDropCnt=255.
  - A hit with iEnable=0: no oGo and oDropCnt unchanged.
- **Wrap and reset:**
  - Coarse preset near 2^24-1 and hit after wrap: expect coarse field 0.
  - rst asserted mid-WAIT: next cycle all outputs are at their reset values, and a subsequent hit is captured normally.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared widths, FSM state type and timestamp field layout for the TDC capture path.
package tdc_pkg;

  localparam int NUM_TAPS   = 36;
  localparam int NUM_DECODE = 8;
  localparam int COARSE_W   = 24;

  // Timestamp word is {err, coarse, fine}, fine in the low bits.
  localparam int TS_FINE_LSB   = 0;
  localparam int TS_COARSE_LSB = TS_FINE_LSB + NUM_DECODE;
  localparam int TS_ERR_BIT    = TS_COARSE_LSB + COARSE_W;
  localparam int TS_W          = TS_ERR_BIT + 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    OUTPUT
  } tdc_state_e;

endpackage

// File: rtl/tdc_hit_detect.sv
// Per-channel hit edge detector: flags the first non-idle sample after an idle one.
module tdc_hit_detect #(
  parameter int   NUM_TAPS = tdc_pkg::NUM_TAPS,
  parameter logic FALLING  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TAPS-1:0] taps,
  output logic                hit
);

  localparam logic [NUM_TAPS-1:0] IDLE_PAT = {NUM_TAPS{FALLING}};

  logic [NUM_TAPS-1:0] prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= IDLE_PAT;
    else     prev <= taps;
  end

  assign hit = (taps != IDLE_PAT) && (prev == IDLE_PAT);

endmodule

// File: rtl/tdc_capture_ctrl.sv
// Capture controller: freezes the tap vector, drives the decoder handshake and
// emits a coarse-tagged timestamp behind a valid/ready interface.
module tdc_capture_ctrl #(
  parameter int   NUM_TAPS   = tdc_pkg::NUM_TAPS,
  parameter int   NUM_DECODE = tdc_pkg::NUM_DECODE,
  parameter int   COARSE_W   = tdc_pkg::COARSE_W,
  parameter logic FALLING    = 1'b0,
  parameter int   TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iEnable,
  input  logic [NUM_TAPS-1:0]            iTaps,
  output logic                           oGo,
  output logic [NUM_TAPS-1:0]            oDecodeIn,
  input  logic                           iFinished,
  input  logic [NUM_DECODE-1:0]          iDecodeOut,
  output logic                           oTsValid,
  output logic [NUM_DECODE+COARSE_W:0]   oTsData,
  input  logic                           iTsReady,
  output logic                           oBusy,
  output logic [7:0]                     oDropCnt
);

  import tdc_pkg::*;

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  tdc_state_e          state, state_next;
  logic                hit, take, expire;
  logic                go_next, valid_next, busy_next;
  logic [COARSE_W-1:0] coarse, coarse_lat;
  logic [TCNT_W-1:0]   tcnt;

  tdc_hit_detect #(
    .NUM_TAPS (NUM_TAPS),
    .FALLING  (FALLING)
  ) u_hit_detect (
    .clk  (clk),
    .rst  (rst),
    .taps (iTaps),
    .hit  (hit)
  );

  assign take   = (state == IDLE) && hit && iEnable;
  assign expire = (tcnt == TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      oGo      <= 1'b0;
      oTsValid <= 1'b0;
      oBusy    <= 1'b0;
    end else begin
      state    <= state_next;
      oGo      <= go_next;
      oTsValid <= valid_next;
      oBusy    <= busy_next;
    end
  end

  // A finished pulse in the expiry cycle still wins because it is tested first in the datapath.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (iFinished || expire) state_next = OUTPUT;
      OUTPUT:  if (iTsReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    go_next    = (state_next == LAUNCH);
    valid_next = (state_next == OUTPUT);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coarse     <= '0;
      coarse_lat <= '0;
      oDecodeIn  <= '0;
      tcnt       <= '0;
      oTsData    <= '0;
      oDropCnt   <= '0;
    end else begin
      coarse <= coarse + 1'b1;
      if (take) begin
        oDecodeIn  <= iTaps;
        coarse_lat <= coarse;
      end
      if (state == LAUNCH)               tcnt <= '0;
      else if (state == WAIT && !expire) tcnt <= tcnt + 1'b1;
      if (state == WAIT) begin
        if (iFinished)   oTsData <= {1'b0, coarse_lat, iDecodeOut};
        else if (expire) oTsData <= {1'b1, coarse_lat, {NUM_DECODE{1'b0}}};
      end
      // Hits that arrive while a transaction is in flight are lost; count them.
      if (state != IDLE && hit && iEnable && oDropCnt != 8'hFF)
        oDropCnt <= oDropCnt + 1'b1;
    end
  end

endmodule
